// File: rtl/dot_mac_seq.sv
// dot_mac_seq: sequential dot-product engine.
// Samples stream into a local buffer. One shared multiplier then walks the
// taps, one per cycle, into an accumulator. The result is offered on a
// valid/ready handshake. Coefficients are loaded through a small write port.
module dot_mac_seq #(
  parameter int TAPS = 10,
  parameter int DW   = 4,
  parameter int ACCW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [DW-1:0]   cfg_data,
  output logic            cfg_err,
  input  logic            x_valid,
  input  logic [DW-1:0]   x_data,
  output logic            x_ready,
  output logic [ACCW-1:0] y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            busy
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IW-1:0]     idx_r;
  logic [ACCW-1:0]   acc_r;
  logic [ACCW-1:0]   y_r;
  logic              cfg_err_r;
  logic [DW-1:0]     h_r    [TAPS];
  logic [DW-1:0]     xbuf_r [TAPS];

  logic              x_fire_s;
  logic              last_idx_s;
  logic              cfg_ok_s;
  logic              cfg_bad_s;
  logic [2*DW-1:0]   prod_s;
  logic [ACCW-1:0]   sum_s;

  // Handshake decode, shared multiply/add and next-state selection.
  always_comb begin
    state_next_s = state_r;
    x_fire_s     = x_valid && (state_r == LOAD);
    last_idx_s   = (idx_r == IW'(TAPS - 1));
    cfg_ok_s     = cfg_we && (state_r != CALC) && (int'(cfg_addr) < TAPS);
    cfg_bad_s    = cfg_we && !cfg_ok_s;
    prod_s       = {{DW{1'b0}}, xbuf_r[idx_r]} * {{DW{1'b0}}, h_r[idx_r]};
    sum_s        = acc_r + {{(ACCW - 2*DW){1'b0}}, prod_s};
    case (state_r)
      LOAD: begin
        if (x_fire_s && last_idx_s) begin
          state_next_s = CALC;
        end else begin
          state_next_s = LOAD;
        end
      end
      CALC: begin
        if (last_idx_s) begin
          state_next_s = OUT;
        end else begin
          state_next_s = CALC;
        end
      end
      OUT: begin
        // y_ready wins over any x_valid in the same cycle: the next sample
        // is taken no earlier than the cycle after the result handshake.
        if (y_ready) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = OUT;
        end
      end
      default: state_next_s = LOAD;
    endcase
  end

  // State register, tap index, accumulator and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= LOAD;
      idx_r   <= '0;
      acc_r   <= '0;
      y_r     <= '0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        LOAD: begin
          if (x_fire_s) begin
            if (last_idx_s) begin
              idx_r <= '0;
              acc_r <= '0;
            end else begin
              idx_r <= idx_r + IW'(1);
            end
          end
        end
        CALC: begin
          if (last_idx_s) begin
            y_r   <= sum_s;
            idx_r <= '0;
          end else begin
            acc_r <= sum_s;
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Coefficient bank and sticky error for rejected writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err_r <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        h_r[i] <= '0;
      end
    end else begin
      if (cfg_ok_s) begin
        h_r[cfg_addr] <= cfg_data;
      end
      if (cfg_bad_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  // Sample buffer, filled in index order during LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        xbuf_r[i] <= '0;
      end
    end else begin
      if (x_fire_s) begin
        xbuf_r[idx_r] <= x_data;
      end
    end
  end

  // x_ready is gated by reset so no sample is offered while reset is held.
  assign x_ready = (state_r == LOAD) && reset;
  assign busy    = (state_r == CALC);
  assign y_valid = (state_r == OUT);
  assign y       = y_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_dot_mac_seq.sv
// Directed testbench for dot_mac_seq. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_dot_mac_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic        cfg_err;
  logic        x_valid;
  logic [3:0]  x_data;
  logic        x_ready;
  logic [31:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Nibble i holds element i (h0 / x0 in the lowest nibble).
  localparam logic [39:0] H_BASIC = 40'h121013241a;
  localparam logic [39:0] H_MAX   = 40'hffffffffff;
  localparam logic [39:0] X_ONE   = 40'h2123143221;
  localparam logic [39:0] X_TWO   = 40'hc9238432a1;
  localparam logic [39:0] X_MAX   = 40'hffffffffff;

  dot_mac_seq dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .x_valid  (x_valid),
    .x_data   (x_data),
    .x_ready  (x_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic write_h(input logic [39:0] hv);
    for (int i = 0; i < 10; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'(i);
      cfg_data = hv[4*i +: 4];
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // cfg_mode: 0 none, 1 write h0=7 during CALC, 2 write h0=5 on the last handshake.
  task automatic run_vec(input string name, input logic [39:0] xv,
                         input logic [31:0] exp, input logic consume,
                         input int cfg_mode);
    y_ready = consume;
    for (int i = 0; i < 10; i++) begin
      x_valid = 1'b1;
      x_data  = xv[4*i +: 4];
      if (cfg_mode == 2 && i == 9) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd5;
      end
      total++;
      if (x_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s_xready i=%0d: got %b want 1", name, i, x_ready);
      end
      @(negedge clk);
    end
    x_valid = 1'b0;
    cfg_we  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({busy, x_ready, y_valid} !== 3'b100) begin
        bad++;
        $display("FAIL %s_calc k=%0d: got busy,xr,yv=%b want 100", name, k,
                 {busy, x_ready, y_valid});
      end
      if (cfg_mode == 1 && k == 3) begin
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 4'd7;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    total++;
    if ({busy, x_ready, y_valid} !== 3'b001 || y !== exp) begin
      bad++;
      $display("FAIL %s_result: got yv=%b y=%0d want yv=1 y=%0d", name, y_valid, y, exp);
    end
    if (consume) begin
      @(negedge clk);
      total++;
      if (y_valid !== 1'b0 || x_ready !== 1'b1 || y !== exp) begin
        bad++;
        $display("FAIL %s_consumed: got yv=%b xr=%b y=%0d want yv=0 xr=1 y=%0d",
                 name, y_valid, x_ready, y, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 4'd0;
    x_valid = 1'b0; x_data = 4'd0; y_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({x_ready, busy, y_valid, cfg_err} !== 4'b0000 || y !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got xr,bz,yv,err=%b y=%0d want 0000 y=0",
               {x_ready, busy, y_valid, cfg_err}, y);
    end
    reset = 1'b1;
    #1;
    total++;
    if (x_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got xr=%b bz=%b want xr=1 bz=0", x_ready, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    write_h(H_BASIC);
    run_vec("basic", X_ONE, 32'd45, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    run_vec("b2b", X_TWO, 32'd86, 1'b1, 0);
  endtask

  task automatic test_max();
    write_h(H_MAX);
    run_vec("max", X_MAX, 32'd2250, 1'b1, 0);
    total++;
    if (y[31:12] !== 20'd0) begin
      bad++;
      $display("FAIL max_upper: got %h want 0", y[31:12]);
    end
  endtask

  task automatic test_backpressure();
    write_h(H_BASIC);
    run_vec("bp", X_ONE, 32'd45, 1'b0, 0);
    for (int j = 0; j < 5; j++) begin
      x_valid = 1'b1;
      x_data  = 4'd7;
      @(negedge clk);
      total++;
      if (y !== 32'd45 || y_valid !== 1'b1 || x_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold j=%0d: got y=%0d yv=%b xr=%b bz=%b want 45 1 0 0",
                 j, y, y_valid, x_ready, busy);
      end
    end
    y_ready = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    total++;
    if (y_valid !== 1'b0 || x_ready !== 1'b1 || y !== 32'd45) begin
      bad++;
      $display("FAIL bp_release: got yv=%b xr=%b y=%0d want 0 1 45", y_valid, x_ready, y);
    end
    run_vec("bp_after", X_ONE, 32'd45, 1'b1, 0);
  endtask

  task automatic test_reject();
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL rej_initial: got cfg_err=%b want 0", cfg_err);
    end
    run_vec("rej_calc", X_ONE, 32'd45, 1'b1, 1);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL rej_err_calc: got cfg_err=%b want 1", cfg_err);
    end
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 4'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL rej_err_addr: got cfg_err=%b want 1", cfg_err);
    end
    run_vec("rej_h0", X_ONE, 32'd45, 1'b1, 0);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL rej_sticky: got cfg_err=%b want 1", cfg_err);
    end
  endtask

  task automatic test_simultaneous_cfg();
    // h0 becomes 5 on the final handshake: 45 - 10*1 + 5*1 = 40.
    run_vec("simul", X_ONE, 32'd40, 1'b1, 2);
  endtask

  task automatic test_reset_mid_calc();
    y_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x_valid = 1'b1;
      x_data  = X_ONE[4*i +: 4];
      @(negedge clk);
    end
    x_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got busy=%b want 1", busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (y !== 32'd0 || {y_valid, busy, x_ready, cfg_err} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_immediate: got y=%0d yv,bz,xr,err=%b want 0 0000",
               y, {y_valid, busy, x_ready, cfg_err});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (x_ready !== 1'b1 || busy !== 1'b0 || y_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_release: got xr=%b bz=%b yv=%b want 1 0 0", x_ready, busy, y_valid);
    end
    @(negedge clk);
    run_vec("midrst_zero_h", X_TWO, 32'd0, 1'b1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max();
    test_backpressure();
    test_reject();
    test_simultaneous_cfg();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_mac_seq.md
Name: dot_mac_seq

Overview:
- Sequencer for the 10-tap, 4-bit dot-product datapath.
- Time-multiplexes one DW x DW multiplier and one accumulator over TAPS taps; one tap is processed per cycle.
- Coefficients h[i] arrive through a register-write port. Samples x[i] arrive on a valid/ready stream.
- The result y is presented on a valid/ready output handshake. This is the area-reduced, flow-controlled replacement for the fully parallel dot product.

Parameters:
- TAPS, 10, number of taps (x/h pairs) per dot product; index counter width is clog2(TAPS).
- DW, 4, unsigned width of each x and h element.
- ACCW, 32, accumulator and y width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- cfg_we  input  1  coefficient write strobe.
- cfg_addr  input  4  coefficient index 0..TAPS-1.
- cfg_data  input  DW  coefficient value.
- cfg_err  output  1  sticky flag: a coefficient write was rejected.
- x_valid  input  1  sample present.
- x_data  input  DW  sample value.
- x_ready  output  1  block accepts a sample this cycle.
- y  output  ACCW  dot-product result.
- y_valid  output  1  y holds a new result.
- y_ready  input  1  consumer accepts y.
- busy  output  1  high in CALC.

Behaviour:
- Reset (reset=0, asynchronous) clears the following, and the clearing applies mid-operation too:
  - state=LOAD, idx=0, acc=0, y=0, y_valid=0, cfg_err=0.
  - All h registers = 0. All x buffer entries = 0.
  - x_ready=0 while reset=0. A partial load or computation is discarded.
- States: LOAD, CALC, OUT.
  - Outputs by state: x_ready=1 only in LOAD; busy=1 only in CALC; y_valid=1 only in OUT.
- LOAD:
  - Each cycle with x_valid&x_ready writes xbuf[idx]=x_data, then idx++.
  - A handshake at idx=TAPS-1 moves to CALC with idx=0, acc=0.
- CALC, one tap per cycle:
  - acc <= acc + zext(xbuf[idx]*h[idx]). The product is 2*DW bits unsigned, zero-extended to ACCW. No saturation; ACCW=32 cannot overflow at default parameters (max 2250).
  - On the cycle idx=TAPS-1: y <= acc + final product, y_valid <= 1, state OUT, idx=0.
- Latency: last sample accepted at edge N gives y_valid=1 and y final after edge N+TAPS (N+10 at default).
- OUT:
  - y and y_valid are held stable while y_ready=0, for any number of cycles.
  - On y_ready=1 (at that edge): y_valid=0, state LOAD. y keeps its last value.
  - A new sample can be accepted no earlier than the next cycle.
- Coefficient writes:
  - In LOAD or OUT, cfg_we with cfg_addr<TAPS writes h[cfg_addr]=cfg_data. The new value is used by the next CALC.
  - The write is ignored, and cfg_err set to 1, when cfg_we=1 and either the state is CALC or cfg_addr>=TAPS.
  - cfg_err clears only on reset.
- x_valid outside LOAD: ignored; no sample is consumed.
- Simultaneous events:
  - cfg_we in the same cycle as the final LOAD handshake is accepted. That CALC uses the new h.
  - y_ready and x_valid in the same OUT cycle: only y_ready is acted on.

Test Plan:
- Basic vector:
  - Stimulus: reset, then write h=10,1,4,2,3,1,0,1,2,1 at addr 0..9. Stream x=1,2,2,3,4,1,3,2,1,2 with x_valid held high. y_ready=1.
  - Required: y=45; y_valid high exactly 10 edges after the 10th x handshake, for one cycle.
- Second vector, back-to-back, same h:
  - Stimulus: x=1,10,2,3,4,8,3,2,9,12.
  - Required: y=86. x_ready is low during CALC/OUT and returns high the cycle after the y handshake.
- Maximum / width:
  - Stimulus: all h=15, all x=15.
  - Required: y=2250; upper bits of y are zero.
- Backpressure:
  - Stimulus: basic vector with y_ready=0 for 5 cycles after y_valid rises.
  - Required: y=45 and y_valid=1 stable for all 5 cycles; x_ready=0 and x_valid ignored throughout; result consumed on the first y_ready=1.
- Rejected config:
  - Stimulus: cfg_we during CALC (addr 0, data 7), then cfg_we in LOAD with addr 12.
  - Required: y is unchanged from the original h (45); cfg_err=1 and stays 1; h[0] still 10.
- Reset mid-CALC:
  - Stimulus: drop reset 4 cycles into CALC, asynchronously between edges.
  - Required: y=0, y_valid=0, busy=0, x_ready=0 immediately. After release, state is LOAD with h all 0, and a full x vector yields y=0.
